// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the decode-to-dispatch queue: lane width, default depth
// and the decoded-instruction payload carried by each entry.
package dispatch_queue_pkg;

  localparam int N_WAY    = 2;
  localparam int DQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] imm;
    logic [7:0]  opcode;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  flags;
  } decoded_instr_t;

  localparam int DQ_DATA_W = $bits(decoded_instr_t);

endpackage

// File: rtl/dq_storage.sv
// Entry array for the dispatch queue: N_WAY write ports starting at the tail
// and N_WAY combinational read ports starting at the head, indices wrap mod DEPTH.
module dq_storage
  import dispatch_queue_pkg::*;
#(
  parameter int N_WAY  = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                      clock,
  input  logic [N_WAY-1:0]          wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_ptr,
  input  logic [N_WAY*DATA_W-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0]  rd_ptr,
  output logic [N_WAY*DATA_W-1:0]   rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Lane writes; enabled lanes always target distinct slots
  always_ff @(posedge clock) begin
    for (int k = 0; k < N_WAY; k++) begin
      if (wr_en[k]) begin
        mem_r[wr_ptr + PW'(k)] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Lane reads from head upward
  always_comb begin
    rd_data = {(N_WAY*DATA_W){1'b0}};
    for (int k = 0; k < N_WAY; k++) begin
      rd_data[k*DATA_W +: DATA_W] = mem_r[rd_ptr + PW'(k)];
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// N-way circular queue between decode and dispatch: pointer/count bookkeeping,
// fetch credit, flush handling and a sticky protocol-violation flag.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int N_WAY  = dispatch_queue_pkg::N_WAY,
  parameter int DEPTH  = DQ_DEPTH,
  parameter int DATA_W = DQ_DATA_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [$clog2(N_WAY):0]       in_count,
  input  logic [N_WAY*DATA_W-1:0]      in_data,
  output logic [$clog2(N_WAY):0]       in_free,
  output logic [N_WAY-1:0]             out_valid,
  output logic [N_WAY*DATA_W-1:0]      out_data,
  input  logic [$clog2(N_WAY):0]       out_taken,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         err
);

  localparam int CW = $clog2(N_WAY) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int KW = PW + 1;

  logic [PW-1:0]           head_r;
  logic [PW-1:0]           tail_r;
  logic [KW-1:0]           count_r;
  logic                    err_r;
  logic [KW-1:0]           space_s;
  logic [CW-1:0]           free_s;
  logic [CW-1:0]           valid_out_s;
  logic [CW-1:0]           in_sat_s;
  logic [CW-1:0]           taken_sat_s;
  logic [CW-1:0]           enq_s;
  logic [CW-1:0]           deq_s;
  logic                    violation_s;
  logic [N_WAY-1:0]        wr_en_s;
  logic [N_WAY*DATA_W-1:0] rd_data_s;

  // Effective enqueue/dequeue amounts, all derived from registered occupancy
  always_comb begin
    space_s = KW'(DEPTH) - count_r;
    if (space_s < KW'(N_WAY)) begin
      free_s = CW'(space_s);
    end else begin
      free_s = CW'(N_WAY);
    end
    if (count_r < KW'(N_WAY)) begin
      valid_out_s = CW'(count_r);
    end else begin
      valid_out_s = CW'(N_WAY);
    end
    if (in_count > CW'(N_WAY)) begin
      in_sat_s = CW'(N_WAY);
    end else begin
      in_sat_s = in_count;
    end
    if (out_taken > CW'(N_WAY)) begin
      taken_sat_s = CW'(N_WAY);
    end else begin
      taken_sat_s = out_taken;
    end
    if (in_sat_s < free_s) begin
      enq_s = in_sat_s;
    end else begin
      enq_s = free_s;
    end
    if (taken_sat_s < valid_out_s) begin
      deq_s = taken_sat_s;
    end else begin
      deq_s = valid_out_s;
    end
    // free_s never exceeds N_WAY, so this also catches oversized in_count
    violation_s = (in_count > free_s) || (out_taken > valid_out_s);
    for (int k = 0; k < N_WAY; k++) begin
      wr_en_s[k] = !reset && !flush && (CW'(k) < enq_s);
    end
  end

  // Pointer, occupancy and sticky error state
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {KW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (violation_s) begin
        err_r <= 1'b1;
      end
      if (flush) begin
        head_r  <= {PW{1'b0}};
        tail_r  <= {PW{1'b0}};
        count_r <= {KW{1'b0}};
      end else begin
        head_r  <= head_r + PW'(deq_s);
        tail_r  <= tail_r + PW'(enq_s);
        count_r <= count_r + KW'(enq_s) - KW'(deq_s);
      end
    end
  end

  dq_storage #(
    .N_WAY  (N_WAY),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_storage (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_ptr  (tail_r),
    .wr_data (in_data),
    .rd_ptr  (head_r),
    .rd_data (rd_data_s)
  );

  // Output lanes, zeroed beyond current occupancy
  always_comb begin
    out_valid = {N_WAY{1'b0}};
    out_data  = {(N_WAY*DATA_W){1'b0}};
    for (int i = 0; i < N_WAY; i++) begin
      out_valid[i] = count_r > KW'(i);
      if (out_valid[i]) begin
        out_data[i*DATA_W +: DATA_W] = rd_data_s[i*DATA_W +: DATA_W];
      end else begin
        out_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  assign in_free = free_s;
  assign count   = count_r;
  assign err     = err_r;

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue (N_WAY=2, DEPTH=8, DATA_W=32): a queue-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_dispatch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  in_count;
  logic [63:0] in_data;
  logic [1:0]  in_free;
  logic [1:0]  out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_taken;
  logic [3:0]  count;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  bit          merr  = 1'b0;
  bit          ready = 1'b0;

  dispatch_queue #(
    .N_WAY  (2),
    .DEPTH  (8),
    .DATA_W (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_count  (in_count),
    .in_data   (in_data),
    .in_free   (in_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_taken (out_taken),
    .count     (count),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of words updated by the queue rules
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        mq.delete();
        merr  = 1'b0;
        ready = 1'b1;
      end else if (ready) begin
        int sz, fr, vo, ic, ot, na, nd;
        sz = mq.size();
        fr = (8 - sz < 2) ? 8 - sz : 2;
        vo = (sz < 2) ? sz : 2;
        ic = int'(in_count);
        ot = int'(out_taken);
        if (ic > fr || ot > vo) merr = 1'b1;
        if (flush) begin
          mq.delete();
        end else begin
          nd = (ot < vo) ? ot : vo;
          na = (ic < fr) ? ic : fr;
          for (int k = 0; k < nd; k++) void'(mq.pop_front());
          for (int k = 0; k < na; k++) mq.push_back(in_data[k*32 +: 32]);
        end
      end
    end
  end

  // Compare process: mid-cycle, DUT outputs against the model
  initial begin
    forever begin
      @(negedge clock);
      if (ready) begin
        int sz, fr;
        logic [31:0] lane_exp;
        sz = mq.size();
        fr = (8 - sz < 2) ? 8 - sz : 2;
        chk("model_count", 64'(count), 64'(sz));
        chk("model_in_free", 64'(in_free), 64'(fr));
        chk("model_err", 64'(err), 64'(merr));
        for (int i = 0; i < 2; i++) begin
          lane_exp = (i < sz) ? mq[i] : 32'd0;
          chk("model_out_valid", 64'(out_valid[i]), 64'(i < sz));
          chk("model_out_data", 64'(out_data[i*32 +: 32]), 64'(lane_exp));
        end
      end
    end
  end

  task automatic drive(input logic [1:0] ic, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] ot, input logic fl);
    in_count  = ic;
    in_data   = {d1, d0};
    out_taken = ot;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset then idle
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_in_free", 64'(in_free), 64'd2);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_err", 64'(err), 64'd0);
    end

    // Fill with 1..8, then overflow attempt
    for (int i = 0; i < 4; i++) begin
      drive(2'd2, 32'(2*i+1), 32'(2*i+2), 2'd0, 1'b0);
      tick();
      chk("fill_count", 64'(count), 64'(2*(i+1)));
    end
    chk("full_in_free", 64'(in_free), 64'd0);
    drive(2'd2, 32'd99, 32'd98, 2'd0, 1'b0);
    tick();
    chk("overflow_count", 64'(count), 64'd8);
    chk("overflow_err", 64'(err), 64'd1);
    chk("full_lanes", out_data, {32'd2, 32'd1});

    // Drain while fetch tries to write into a full queue
    drive(2'd2, 32'd77, 32'd78, 2'd2, 1'b0);
    tick();
    chk("drain_count", 64'(count), 64'd6);
    chk("drain_lanes", out_data, {32'd4, 32'd3});
    chk("drain_in_free", 64'(in_free), 64'd2);

    // Enqueue across the wrap, then drain everything in order
    drive(2'd2, 32'd9, 32'd10, 2'd0, 1'b0);
    tick();
    chk("wrap_count", 64'(count), 64'd8);
    for (int j = 0; j < 4; j++) begin
      chk("wrap_lanes", out_data, {32'(2*j+4), 32'(2*j+3)});
      drive(2'd0, 32'd0, 32'd0, 2'd2, 1'b0);
      tick();
    end
    chk("empty_count", 64'(count), 64'd0);
    chk("empty_out_valid", 64'(out_valid), 64'd0);

    // Simultaneous enqueue and dequeue from count=3
    drive(2'd2, 32'd11, 32'd12, 2'd0, 1'b0);
    tick();
    drive(2'd1, 32'd13, 32'd0, 2'd0, 1'b0);
    tick();
    chk("sim_pre_count", 64'(count), 64'd3);
    drive(2'd2, 32'd14, 32'd15, 2'd1, 1'b0);
    tick();
    chk("sim_count", 64'(count), 64'd4);
    chk("sim_lanes", out_data, {32'd13, 32'd12});

    // Flush beats same-cycle enqueue and dequeue
    drive(2'd1, 32'd16, 32'd0, 2'd0, 1'b0);
    tick();
    chk("flush_pre_count", 64'(count), 64'd5);
    drive(2'd2, 32'd30, 32'd31, 2'd2, 1'b1);
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_free", 64'(in_free), 64'd2);
    drive(2'd1, 32'd20, 32'd0, 2'd0, 1'b0);
    tick();
    chk("post_flush_lanes", out_data, {32'd0, 32'd20});
    chk("post_flush_count", 64'(count), 64'd1);

    // Reset mid-operation clears contents and err
    reset = 1'b1;
    drive(2'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    tick();
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    reset = 1'b0;

    // in_count above N_WAY: two lanes accepted, err set
    drive(2'd3, 32'd40, 32'd41, 2'd0, 1'b0);
    tick();
    chk("sat_count", 64'(count), 64'd2);
    chk("sat_err", 64'(err), 64'd1);
    chk("sat_lanes", out_data, {32'd41, 32'd40});

    // Reset together with flush
    reset = 1'b1;
    drive(2'd0, 32'd0, 32'd0, 2'd0, 1'b1);
    tick();
    chk("rst_flush_count", 64'(count), 64'd0);
    chk("rst_flush_err", 64'(err), 64'd0);
    reset = 1'b0;

    // Underflow and sticky err
    drive(2'd1, 32'd21, 32'd0, 2'd0, 1'b0);
    tick();
    chk("uf_pre_count", 64'(count), 64'd1);
    drive(2'd0, 32'd0, 32'd0, 2'd2, 1'b0);
    tick();
    chk("uf_count", 64'(count), 64'd0);
    chk("uf_err", 64'(err), 64'd1);
    drive(2'd0, 32'd0, 32'd0, 2'd0, 1'b1);
    tick();
    chk("uf_flush_err", 64'(err), 64'd1);
    drive(2'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    reset = 1'b1;
    tick();
    chk("uf_reset_err", 64'(err), 64'd0);
    reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
